// File: rtl/main_nios2_processor_oci_dct_packer.sv
// Packs 2-bit OCI trace symbols LSB-first into a 30-bit word with a symbol count
// and hands the word to the trace bench stage. A partial word is flushed after an
// idle timeout or when a test end is requested; after the end request's last word
// is taken the block parks in StEnded until reset.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   sym_valid_i/sym_data_i  offered trace symbol; sym_ready_o accepts it
//   test_end_req_i          request end of test (level or pulse)
//   dct_buffer_o            packed word, slot k = bits [2k+1:2k], unused slots 0
//   dct_count_o             valid symbols in dct_buffer_o (non-zero while word_valid_o)
//   word_valid_o/word_ready_i  word handshake; word held stable while stalled
//   test_ending_o           high between the end request and test_has_ended_o
//   test_has_ended_o        sticky end-of-test flag
module main_nios2_processor_oci_dct_packer #(
  parameter int unsigned SymW      = 2,
  parameter int unsigned Slots     = 15,
  parameter int unsigned IdleFlush = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sym_valid_i,
  input  logic [SymW-1:0]         sym_data_i,
  output logic                    sym_ready_o,
  input  logic                    test_end_req_i,
  output logic [SymW*Slots-1:0]   dct_buffer_o,
  output logic [3:0]              dct_count_o,
  output logic                    word_valid_o,
  input  logic                    word_ready_i,
  output logic                    test_ending_o,
  output logic                    test_has_ended_o
);

  localparam int unsigned WordW = SymW * Slots;
  localparam int unsigned IdleW = (IdleFlush > 0) ? $clog2(IdleFlush + 1) : 1;
  localparam logic [3:0]       SlotsC = 4'(Slots);
  localparam logic [IdleW-1:0] IdleC  = IdleW'(IdleFlush);

  typedef enum logic [1:0] {StFill, StEmit, StDrain, StEnded} state_e;

  state_e           state_q, state_d;
  logic [WordW-1:0] acc_q, acc_d;     // symbols still being collected
  logic [3:0]       cnt_q, cnt_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [WordW-1:0] word_q, word_d;   // word presented to the consumer
  logic [3:0]       wcnt_q, wcnt_d;
  logic             ending_q, ending_d;

  logic             accept, handshake, timeout;
  logic [WordW-1:0] acc_n;
  logic [3:0]       cnt_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StFill;
      acc_q    <= '0;
      cnt_q    <= '0;
      idle_q   <= '0;
      word_q   <= '0;
      wcnt_q   <= '0;
      ending_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      word_q   <= word_d;
      wcnt_q   <= wcnt_d;
      ending_q <= ending_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    word_d      = word_q;
    wcnt_d      = wcnt_q;
    ending_d    = ending_q;
    acc_n       = acc_q;
    cnt_n       = cnt_q;
    timeout     = 1'b0;
    sym_ready_o = 1'b0;
    word_valid_o = (state_q == StEmit) || (state_q == StDrain);

    unique case (state_q)
      StFill:  sym_ready_o = 1'b1;
      StEmit:  sym_ready_o = word_ready_i;
      StDrain: sym_ready_o = 1'b0;
      StEnded: sym_ready_o = 1'b0;
    endcase

    accept    = sym_valid_i && sym_ready_o;
    handshake = word_valid_o && word_ready_i;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          acc_n[int'(cnt_q)*SymW +: SymW] = sym_data_i;
          cnt_n = cnt_q + 1'b1;
        end
        idle_d  = (accept || cnt_q == '0) ? '0 : idle_q + 1'b1;
        timeout = (IdleFlush != 0) && !accept && (cnt_q != '0) && (idle_d == IdleC);
        acc_d   = acc_n;
        cnt_d   = cnt_n;
        // The end request outranks both a full word and an idle timeout.
        if (test_end_req_i) begin
          if (cnt_n != '0) begin
            state_d  = StDrain;
            ending_d = 1'b1;
            word_d   = acc_n;
            wcnt_d   = cnt_n;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d = StEnded;
          end
          idle_d = '0;
        end else if (cnt_n == SlotsC || timeout) begin
          state_d = StEmit;
          word_d  = acc_n;
          wcnt_d  = cnt_n;
          acc_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
        end
      end
      StEmit: begin
        if (test_end_req_i) ending_d = 1'b1;
        if (handshake) begin
          // A symbol taken alongside the handshake starts the next word in slot 0.
          acc_n = '0;
          cnt_n = '0;
          if (accept) begin
            acc_n[SymW-1:0] = sym_data_i;
            cnt_n = 4'd1;
          end
          if (ending_d) begin
            if (cnt_n != '0) begin
              state_d = StDrain;
              word_d  = acc_n;
              wcnt_d  = cnt_n;
            end else begin
              state_d  = StEnded;
              ending_d = 1'b0;
            end
            acc_d = '0;
            cnt_d = '0;
          end else begin
            state_d = StFill;
            acc_d   = acc_n;
            cnt_d   = cnt_n;
          end
        end
      end
      StDrain: begin
        if (handshake) begin
          state_d  = StEnded;
          ending_d = 1'b0;
        end
      end
      StEnded: ;
    endcase
  end

  assign dct_buffer_o     = word_q;
  assign dct_count_o      = wcnt_q;
  assign test_ending_o    = ending_q;
  assign test_has_ended_o = (state_q == StEnded);

endmodule

// File: tb/tb_main_nios2_processor_oci_dct_packer.sv
module tb_main_nios2_processor_oci_dct_packer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_data = '0;
  logic        sym_ready;
  logic        test_end_req = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        test_ending;
  logic        test_has_ended;

  int errors = 0;
  int n_checks = 0;

  typedef struct {
    logic [29:0] wbuf;
    logic [3:0]  cnt;
  } word_t;
  word_t exp_q[$];

  typedef struct {
    int          n;
    int          a;
    int          b;
    bit          idle;
    logic [29:0] exp_buf;
    logic [3:0]  exp_cnt;
  } vec_t;
  vec_t vecs[6];

  main_nios2_processor_oci_dct_packer dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .sym_valid_i      (sym_valid),
    .sym_data_i       (sym_data),
    .sym_ready_o      (sym_ready),
    .test_end_req_i   (test_end_req),
    .dct_buffer_o     (dct_buffer),
    .dct_count_o      (dct_count),
    .word_valid_o     (word_valid),
    .word_ready_i     (word_ready),
    .test_ending_o    (test_ending),
    .test_has_ended_o (test_has_ended)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [29:0] b, input logic [3:0] c);
    word_t w;
    w.wbuf = b;
    w.cnt  = c;
    exp_q.push_back(w);
  endtask

  // Words are checked at the handshake against the scoreboard queue.
  always @(negedge clk) begin
    word_t w;
    #3;
    if (rst_ni && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        errors++;
        $display("FAIL word_unexpected: got %0h/%0d expected none", dct_buffer, dct_count);
      end else begin
        w = exp_q.pop_front();
        check("word_buf", {2'b00, dct_buffer}, {2'b00, w.wbuf});
        check("word_cnt", {28'd0, dct_count}, {28'd0, w.cnt});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [1:0] s);
    int budget = 0;
    sym_valid = 1'b1;
    sym_data  = s;
    #1;
    while (!sym_ready) begin
      if (budget > 200) begin
        n_checks++;
        errors++;
        $display("FAIL send_timeout: got no sym_ready expected accept");
        sym_valid = 1'b0;
        return;
      end
      budget++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic send_seq(input int n, input int a, input int b);
    for (int k = 0; k < n; k++) send(2'((a * k + b) % 4));
    sym_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    sym_valid = 1'b0;
    test_end_req = 1'b0;
    word_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
    check({tag, "_count"}, {28'd0, dct_count}, 32'd0);
    check({tag, "_buf"}, {2'b00, dct_buffer}, 32'd0);
    check({tag, "_ending"}, {31'd0, test_ending}, 32'd0);
    check({tag, "_ended"}, {31'd0, test_has_ended}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{n: 15, a: 1, b: 0, idle: 1'b0, exp_buf: 30'h24E4E4E4, exp_cnt: 4'd15};
    vecs[1] = '{n: 4,  a: 0, b: 3, idle: 1'b1, exp_buf: 30'h000000FF, exp_cnt: 4'd4};
    vecs[2] = '{n: 15, a: 0, b: 2, idle: 1'b0, exp_buf: 30'h2AAAAAAA, exp_cnt: 4'd15};
    vecs[3] = '{n: 5,  a: 1, b: 1, idle: 1'b1, exp_buf: 30'h00000139, exp_cnt: 4'd5};
    vecs[4] = '{n: 15, a: 3, b: 0, idle: 1'b0, exp_buf: 30'h2C6C6C6C, exp_cnt: 4'd15};
    vecs[5] = '{n: 1,  a: 0, b: 1, idle: 1'b1, exp_buf: 30'h00000001, exp_cnt: 4'd1};

    do_reset();
    #1;
    check_idle_outputs("reset");

    // Table: full words appear one cycle after the 15th symbol, partial words
    // exactly 64 idle cycles after the last symbol.
    word_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].exp_buf, vecs[i].exp_cnt);
      send_seq(vecs[i].n, vecs[i].a, vecs[i].b);
      if (vecs[i].idle) begin
        repeat (63) @(negedge clk);
        #1;
        check("idle_early_valid", {31'd0, word_valid}, 32'd0);
        @(negedge clk);
      end
      #1;
      check("vec_valid", {31'd0, word_valid}, 32'd1);
      check("vec_count", {28'd0, dct_count}, {28'd0, vecs[i].exp_cnt});
    end
    repeat (3) @(negedge clk);

    // Stalled full word, released with a symbol offered.
    do_reset();
    push(30'h39393939, 4'd15);
    send_seq(15, 1, 1);
    sym_valid = 1'b1;
    sym_data  = 2'd2;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_valid", {31'd0, word_valid}, 32'd1);
      check("stall_buf", {2'b00, dct_buffer}, 32'h39393939);
      check("stall_count", {28'd0, dct_count}, 32'd15);
      check("stall_sym_ready", {31'd0, sym_ready}, 32'd0);
      @(negedge clk);
    end
    push(30'h2, 4'd1);
    word_ready = 1'b1;
    #1;
    check("release_sym_ready", {31'd0, sym_ready}, 32'd1);
    @(negedge clk);
    sym_valid = 1'b0;
    repeat (64) @(negedge clk);
    #1;
    check("release_flush_valid", {31'd0, word_valid}, 32'd1);
    repeat (2) @(negedge clk);

    // End request with a partial word pending.
    do_reset();
    word_ready = 1'b1;
    send_seq(7, 0, 1);
    word_ready   = 1'b0;
    test_end_req = 1'b1;
    @(negedge clk);
    test_end_req = 1'b0;
    #1;
    check("end_ending", {31'd0, test_ending}, 32'd1);
    check("end_valid", {31'd0, word_valid}, 32'd1);
    check("end_count", {28'd0, dct_count}, 32'd7);
    check("end_buf", {2'b00, dct_buffer}, 32'h1555);
    check("end_sym_ready", {31'd0, sym_ready}, 32'd0);
    check("end_not_ended", {31'd0, test_has_ended}, 32'd0);
    push(30'h1555, 4'd7);
    word_ready = 1'b1;
    sym_valid  = 1'b1;
    @(negedge clk);
    #1;
    check("ended_flag", {31'd0, test_has_ended}, 32'd1);
    check("ended_ending", {31'd0, test_ending}, 32'd0);
    check("ended_sym_ready", {31'd0, sym_ready}, 32'd0);
    check("ended_valid", {31'd0, word_valid}, 32'd0);
    sym_valid = 1'b0;

    // End request with nothing accumulated.
    do_reset();
    test_end_req = 1'b1;
    @(negedge clk);
    test_end_req = 1'b0;
    #1;
    check("empty_end_ended", {31'd0, test_has_ended}, 32'd1);
    check("empty_end_valid", {31'd0, word_valid}, 32'd0);

    // Idle timeout and end request in the same cycle: end request wins.
    do_reset();
    send_seq(2, 0, 3);
    repeat (63) @(negedge clk);
    test_end_req = 1'b1;
    @(negedge clk);
    test_end_req = 1'b0;
    #1;
    check("race_ending", {31'd0, test_ending}, 32'd1);
    check("race_count", {28'd0, dct_count}, 32'd2);
    push(30'hF, 4'd2);
    word_ready = 1'b1;
    @(negedge clk);
    #1;
    check("race_ended", {31'd0, test_has_ended}, 32'd1);

    // Asynchronous reset with a stalled word, then mid-accumulation.
    do_reset();
    send_seq(15, 0, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("async_rst_word");
    @(negedge clk);
    rst_ni = 1'b1;
    word_ready = 1'b1;
    send_seq(9, 0, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("async_rst_acc");
    @(negedge clk);
    rst_ni = 1'b1;
    push(30'h2C6C6C6C, 4'd15);
    send_seq(15, 3, 0);
    #1;
    check("post_rst_valid", {31'd0, word_valid}, 32'd1);
    check("post_rst_count", {28'd0, dct_count}, 32'd15);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
